// File: rtl/mem_access_responder.sv
// mem_access_responder: latency/hold-modelled word memory behind the OCP bridge; MEM_ACCESS_STATS_EN adds rd/wr counters
module mem_access_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_access_request,
  input  logic                  mem_access_type,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_access_complete,
  input  logic                  hold,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [7:0] CNT_INIT = LATENCY > 1 ? 8'(LATENCY - 2) : 8'd0;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic complete_q, busy_q, fire;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  // the *_d capture values are used at the DONE transition so LATENCY=1 sees the fresh request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (mem_access_request && !hold) begin
        type_d  = mem_access_type;
        addr_d  = mem_address;
        data_d  = mem_write_data;
        state_d = (LATENCY == 1) ? DONE : WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: if (!hold) begin
        state_d = (cnt_q == 8'd0) ? DONE : WAIT;
        cnt_d   = (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    fire    = (state_d == DONE);
    rdata_d = (fire && !type_d) ? mem_q[addr_d] : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      type_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      complete_q <= fire;
      busy_q     <= (state_d != IDLE);
      if (fire && type_d) mem_q[addr_d] <= data_d;
    end
  end
  assign mem_read_data       = rdata_q;
  assign mem_access_complete = complete_q;
  assign busy                = busy_q;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  always_comb begin
    rd_cnt_d = (fire && !type_d && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;
    wr_cnt_d = (fire && type_d && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
  end
  always_ff @(posedge clk) begin
    rd_cnt_q <= reset ? 16'd0 : rd_cnt_d;
    wr_cnt_q <= reset ? 16'd0 : wr_cnt_d;
  end
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif
endmodule

// File: tb/tb_mem_access_responder.sv
// tb_mem_access_responder: directed vector table plus hold/reset/back-to-back corner sequences
module tb_mem_access_responder;
  logic clk = 1'b0;
  logic reset;
  logic req, typ, hold;
  logic [4:0] addr;
  logic [31:0] wdata, rdata;
  logic cmp, busy;
  logic [15:0] rdc, wrc;
  logic req4, hold4, cmp4, busy4;
  logic [31:0] rdata4;
  logic [15:0] rdc4, wrc4;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  mem_access_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .mem_access_request(req), .mem_access_type(typ),
    .mem_address(addr), .mem_write_data(wdata), .mem_read_data(rdata),
    .mem_access_complete(cmp), .hold(hold), .busy(busy), .rd_count(rdc), .wr_count(wrc)
  );
  mem_access_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .mem_access_request(req4), .mem_access_type(1'b0),
    .mem_address(5'd0), .mem_write_data(32'd0), .mem_read_data(rdata4),
    .mem_access_complete(cmp4), .hold(hold4), .busy(busy4), .rd_count(rdc4), .wr_count(wrc4)
  );
  typedef struct {
    logic        typ;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic access(input logic t, input logic [4:0] a, input logic [31:0] d, input bit scramble,
                        output int n, output logic [31:0] rd, output logic b1);
    @(negedge clk);
    req = 1'b1; typ = t; addr = a; wdata = d;
    @(posedge clk);
    n = 0; rd = 'x; b1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) b1 = busy;
      if (scramble && i == 1) begin
        typ = ~t; addr = a ^ 5'h1f; wdata = ~d;
      end
      if (cmp) begin
        n = i; rd = rdata;
        break;
      end
    end
    req = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n, got;
    logic [31:0] rd;
    logic b1;
    vecs[0] = '{1'b0, 5'd5,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd3,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 5'd3,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd10, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd31, 32'h0000FFFF, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 5'd31, 32'h0,        32'h0000FFFF};
    vecs[6] = '{1'b0, 5'd10, 32'h0,        32'hA5A5A5A5};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        32'h0};
    reset = 1'b1; req = 1'b0; typ = 1'b0; hold = 1'b0; addr = '0; wdata = '0;
    req4 = 1'b0; hold4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmp", 32'(cmp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rdc", 32'(rdc), 32'd0);
    check("rst_wrc", 32'(wrc), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    reset = 1'b0;
    for (int v = 0; v < 8; v++) begin
      access(vecs[v].typ, vecs[v].addr, vecs[v].wdata, 1'b0, n, rd, b1);
      check($sformatf("vec%0d_latency", v), 32'(n), 32'd2);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_busy_wait", v), 32'(b1), 32'd1);
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cmp", 32'(cmp), 32'd0);
`ifdef MEM_ACCESS_STATS_EN
    check("stats_rd", 32'(rdc), 32'd5);
    check("stats_wr", 32'(wrc), 32'd3);
    @(negedge clk);
    force dut2.wr_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut2.wr_cnt_q;
    access(1'b1, 5'd1, 32'h1, 1'b0, n, rd, b1);
    @(negedge clk);
    check("stats_wr_sat", 32'(wrc), 32'h0000FFFF);
`else
    check("nostats_rd", 32'(rdc), 32'd0);
    check("nostats_wr", 32'(wrc), 32'd0);
`endif
    // continuously held read: accept every LATENCY+1 cycles, one pulse each
    @(negedge clk);
    req = 1'b1; typ = 1'b0; addr = 5'd7;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("held_cmp%0d", i), 32'(cmp), 32'(i % 3 == 1));
    end
    req = 1'b0;
    check("held_rdata", rdata, 32'd0);
    @(negedge clk);
    req4 = 1'b1; hold4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_idle_busy%0d", i), 32'(busy4), 32'd0);
      check($sformatf("hold_idle_cmp%0d", i), 32'(cmp4), 32'd0);
    end
    req4 = 1'b0; hold4 = 1'b0;
    for (int hc = 0; hc <= 3; hc += 3) begin
      @(negedge clk);
      req4 = 1'b1; hold4 = 1'b0;
      @(posedge clk);
      got = 0;
      for (int k = 1; k <= 15; k++) begin
        @(negedge clk);
        if (cmp4) begin
          got = k;
          break;
        end
        hold4 = (k <= hc);
      end
      req4 = 1'b0; hold4 = 1'b0;
      check($sformatf("l4_hold%0d_latency", hc), 32'(got), 32'(4 + hc));
    end
    access(1'b0, 5'd3, 32'h0, 1'b0, n, rd, b1);
    check("pre_rst_rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    req = 1'b1; typ = 1'b1; addr = 5'd9; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd1);
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_cmp", 32'(cmp), 32'd0);
    check("midrst_busy_after", 32'(busy), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    @(negedge clk);
    check("midrst_cmp2", 32'(cmp), 32'd0);
    access(1'b0, 5'd9, 32'h0, 1'b0, n, rd, b1);
    check("midrst_read9", rd, 32'd0);
    access(1'b0, 5'd3, 32'h0, 1'b0, n, rd, b1);
    check("midrst_read3", rd, 32'd0);
    access(1'b1, 5'd9, 32'h12345678, 1'b1, n, rd, b1);
    check("scr_latency", 32'(n), 32'd2);
    access(1'b0, 5'd9, 32'h0, 1'b0, n, rd, b1);
    check("scr_read9", rd, 32'h12345678);
    access(1'b0, 5'd22, 32'h0, 1'b0, n, rd, b1);
    check("scr_read22", rd, 32'd0);
`ifndef MEM_ACCESS_STATS_EN
    check("final_rdc", 32'(rdc), 32'd0);
    check("final_wrc", 32'(wrc), 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
